// File: rtl/ps2_key_rx_pkg.sv
// Shared constants and types for the PS/2 key receiver.
// Prefix bytes, the silently dropped status codes, and the frame FSM state type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Number of bytes following E1 that belong to the Pause sequence
    localparam int unsigned PAUSE_SKIP = 7;

    localparam int unsigned N_FILTERED = 6;
    localparam logic [7:0] FILTERED_CODES [N_FILTERED] =
        '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic is_filtered(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_FILTERED; i++) begin
            if (code == FILTERED_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// PS/2 line inputs and key-event outputs of the receiver.
// master is the receiver side, slave is the line driver / key consumer side.
interface ps2_key_rx_if;

    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (
        input  ps2_clk_in,
        input  ps2_data_in,
        output ps2_key,
        output frame_err,
        output busy
    );

    modport slave (
        output ps2_clk_in,
        output ps2_data_in,
        input  ps2_key,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock line and
// emits a one-cycle strobe on each filtered falling clock edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic data_sync,
    output logic fall_edge
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_ff;
    logic [1:0]    data_ff;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_ff    <= '1;
            data_ff   <= '1;
            filt      <= 1'b1;
            cnt       <= '0;
            fall_edge <= 1'b0;
        end else begin
            clk_ff    <= {clk_ff[0], ps2_clk_in};
            data_ff   <= {data_ff[0], ps2_data_in};
            fall_edge <= 1'b0;
            // Level flips on the FILTER_LEN-th consecutive differing sample
            if (clk_ff[1] != filt) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt      <= ~filt;
                    cnt       <= '0;
                    fall_edge <= filt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, decodes E0/F0/E1
// prefixes and emits key events on the toggle-flagged ps2_key bus.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic             clk_sys,
    input logic             reset_n,
    ps2_key_rx_if.master    bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned SW = $clog2(PAUSE_SKIP + 1);

    logic data_sync;
    logic fall_edge;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (bus.ps2_clk_in),
        .ps2_data_in (bus.ps2_data_in),
        .data_sync   (data_sync),
        .fall_edge   (fall_edge)
    );

    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_rdy_q, byte_rdy_d;
    logic          err_q, err_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_rdy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_rdy_q <= byte_rdy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_rdy_d = 1'b0;
        err_d      = 1'b0;

        if (state_q == IDLE || fall_edge) tmo_d = '0;
        else                              tmo_d = tmo_q + 1'b1;

        // A falling edge takes priority over an expiring timeout
        if (fall_edge) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sync) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d   = {data_sync, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_sync;
                    state_d = STOP;
                end
                STOP: begin
                    if (data_sync && (^{shreg_q, par_q})) byte_rdy_d = 1'b1;
                    else                                  err_d      = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    logic [10:0]   key_q;
    logic          ext_q;
    logic          rel_q;
    logic [SW-1:0] skip_q;

    // shreg_q still holds the completed byte while byte_rdy_q is high
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
        end else if (byte_rdy_q) begin
            if (skip_q != '0) begin
                skip_q <= skip_q - 1'b1;
            end else if (shreg_q == PS2_PAUSE) begin
                skip_q <= SW'(PAUSE_SKIP);
            end else if (shreg_q == PS2_EXT) begin
                ext_q <= 1'b1;
            end else if (shreg_q == PS2_REL) begin
                rel_q <= 1'b1;
            end else if (is_filtered(shreg_q)) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else begin
                key_q <= {~key_q[10], ~rel_q, ext_q, shreg_q};
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
